// File: rtl/gb_cart_bus_master.sv
// Game Boy cartridge bus master: one timed SETUP/STROBE/HOLD bus cycle per host request.
// Optional macro GB_CART_BUS_MASTER_AUTO_BANK_EN adds MBC5 bank-select writes ahead of banked ROM reads.
//
// state  | meaning
// IDLE   | waiting for a host request (cmd_ready=1)
// SETUP  | address/data stable, strobes high
// STROBE | RD_n or WR_n low
// HOLD   | strobes high, address/data still held
// DONE   | one-cycle rsp_valid pulse
module gb_cart_bus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic [8:0]  cmd_bank,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] gb_addr,
  output logic [7:0]  gb_dout,
  output logic        gb_dout_oe,
  input  logic [7:0]  gb_din,
  output logic        gb_rd_n,
  output logic        gb_wr_n,
  output logic        gb_cs_n
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        run_q;
  logic        busy;

`ifdef GB_CART_BUS_MASTER_AUTO_BANK_EN
  localparam logic [1:0] PH_LO   = 2'd0;
  localparam logic [1:0] PH_HI   = 2'd1;
  localparam logic [1:0] PH_HOST = 2'd2;

  logic [1:0]  phase_q, phase_d;
  logic [15:0] host_addr_q, host_addr_d;
  logic        host_bank8_q, host_bank8_d;
  logic [8:0]  bank_q, bank_d;
  logic        lo_vld_q, lo_vld_d, hi_vld_q, hi_vld_d;
  logic        bank_miss;

  assign bank_miss = !cmd_write && (cmd_addr[15:14] == 2'b01) &&
                     (!(lo_vld_q && hi_vld_q) || (cmd_bank != bank_q));
`else
  logic unused_bank;
  assign unused_bank = ^cmd_bank;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      run_q   <= 1'b0;
`ifdef GB_CART_BUS_MASTER_AUTO_BANK_EN
      phase_q      <= PH_HOST;
      host_addr_q  <= '0;
      host_bank8_q <= 1'b0;
      bank_q       <= '0;
      lo_vld_q     <= 1'b0;
      hi_vld_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      run_q   <= 1'b1;
`ifdef GB_CART_BUS_MASTER_AUTO_BANK_EN
      phase_q      <= phase_d;
      host_addr_q  <= host_addr_d;
      host_bank8_q <= host_bank8_d;
      bank_q       <= bank_d;
      lo_vld_q     <= lo_vld_d;
      hi_vld_q     <= hi_vld_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
`ifdef GB_CART_BUS_MASTER_AUTO_BANK_EN
    phase_d      = phase_q;
    host_addr_d  = host_addr_q;
    host_bank8_d = host_bank8_q;
    bank_d       = bank_q;
    lo_vld_d     = lo_vld_q;
    hi_vld_d     = hi_vld_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready = run_q;
        if (run_q && cmd_valid) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          write_d = cmd_write;
`ifdef GB_CART_BUS_MASTER_AUTO_BANK_EN
          phase_d      = PH_HOST;
          host_addr_d  = cmd_addr;
          host_bank8_d = cmd_bank[8];
          if (bank_miss) begin
            phase_d = PH_LO;
            addr_d  = 16'h2000;
            wdata_d = cmd_bank[7:0];
            write_d = 1'b1;
          end
`endif
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else cnt_d = cnt_q - 4'd1;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          if (!write_q) rdata_d = gb_din;
        end else cnt_d = cnt_q - 4'd1;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
`ifdef GB_CART_BUS_MASTER_AUTO_BANK_EN
          // Track the MBC5 bank register from every write that reaches it.
          if (write_q && addr_q[15:12] == 4'h2) begin
            bank_d[7:0] = wdata_q;
            lo_vld_d    = 1'b1;
          end
          if (write_q && addr_q[15:12] == 4'h3) begin
            bank_d[8] = wdata_q[0];
            hi_vld_d  = 1'b1;
          end
          if (phase_q == PH_LO) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
            phase_d = PH_HI;
            addr_d  = 16'h3000;
            wdata_d = {7'b0, host_bank8_q};
          end else if (phase_q == PH_HI) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
            phase_d = PH_HOST;
            addr_d  = host_addr_q;
            write_d = 1'b0;
          end
`endif
        end else cnt_d = cnt_q - 4'd1;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign gb_addr    = addr_q;
  assign gb_dout    = wdata_q;
  assign gb_dout_oe = busy && write_q;
  assign gb_cs_n    = !(busy && addr_q[15:13] == 3'b101);
  assign gb_rd_n    = !(state_q == STROBE && !write_q);
  assign gb_wr_n    = !(state_q == STROBE && write_q);
  assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// Randomized bench for gb_cart_bus_master: per-cycle trace against a bus-cycle list model.
module tb_gb_cart_bus_master;
  localparam int S = 2, ST = 4, H = 2, L = S + ST + H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [8:0]  cmd_bank = '0;
  logic [7:0]  gb_din = '0;
  logic        cmd_ready, rsp_valid, gb_dout_oe, gb_rd_n, gb_wr_n, gb_cs_n;
  logic [7:0]  rsp_rdata, gb_dout;
  logic [15:0] gb_addr;

  int checks = 0, passes = 0;
  logic [7:0] exp_rdata = '0;
  logic [8:0] m_bank = '0;
  bit m_lo_v = 0, m_hi_v = 0;

  always #5 clk = ~clk;

  gb_cart_bus_master #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_bank(cmd_bank),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .gb_addr(gb_addr), .gb_dout(gb_dout),
    .gb_dout_oe(gb_dout_oe), .gb_din(gb_din), .gb_rd_n(gb_rd_n), .gb_wr_n(gb_wr_n),
    .gb_cs_n(gb_cs_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) step();
    checks++;
    if ({gb_rd_n, gb_wr_n, gb_cs_n, gb_dout_oe, rsp_valid, cmd_ready} !== 6'b111000)
      $display("FAIL reset_ctrl got %b want 111000",
               {gb_rd_n, gb_wr_n, gb_cs_n, gb_dout_oe, rsp_valid, cmd_ready});
    else passes++;
    checks++;
    if ({gb_addr, gb_dout, rsp_rdata} !== 32'h0)
      $display("FAIL reset_data got %h want 00000000", {gb_addr, gb_dout, rsp_rdata});
    else passes++;
    rst_n = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", cmd_ready);
    else passes++;
    exp_rdata = '0;
    m_lo_v = 0;
    m_hi_v = 0;
  endtask

  task automatic test_transactions();
    for (int n = 0; n < 40; n++) begin
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
      logic [8:0]  bk;
      logic [15:0] ba[3];
      logic        bw[3];
      logic [7:0]  bd[3];
      int nb, total;
      w  = 1'($urandom);
      a  = 16'($urandom);
      d  = 8'($urandom);
      case ($urandom_range(0, 2))
        0: bk = 9'h105;
        1: bk = 9'h003;
        default: bk = 9'h1FF;
      endcase
      case ($urandom_range(0, 4))
        1: begin a = {2'b01, 14'($urandom)}; w = 1'b0; end
        2: begin a = {4'h2, 12'($urandom)}; w = 1'b1; end
        3: begin a = {4'h3, 12'($urandom)}; w = 1'b1; end
        4: a = {3'b101, 13'($urandom)};
        default: ;
      endcase
      if (n < 2) begin w = 1'b0; a = 16'h4000; bk = 9'h105; end
      if (n == 2) begin w = 1'b0; a = 16'h0150; end
      if (n == 3) begin w = 1'b1; a = 16'hA000; d = 8'h5A; end

      nb = 0;
`ifdef GB_CART_BUS_MASTER_AUTO_BANK_EN
      if (!w && a[15:14] == 2'b01 && (!(m_lo_v && m_hi_v) || bk != m_bank)) begin
        ba[0] = 16'h2000; bw[0] = 1'b1; bd[0] = bk[7:0];
        ba[1] = 16'h3000; bw[1] = 1'b1; bd[1] = {7'b0, bk[8]};
        nb = 2;
      end
`endif
      ba[nb] = a; bw[nb] = w; bd[nb] = d;
      nb++;
      total = nb * L + 1;

      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_bank = bk;
      step();
      for (int k = 1; k <= total; k++) begin
        int idx, off;
        bit stb, last;
        logic [3:0] es;
        idx  = (k - 1) / L;
        off  = (k - 1) % L;
        stb  = (k < total) && off >= S && off < S + ST;
        last = stb && off == S + ST - 1;
        if (k < total)
          es = {!(stb && !bw[idx]), !(stb && bw[idx]), !(ba[idx][15:13] == 3'b101), bw[idx]};
        else
          es = 4'b1110;
        checks++;
        if ({gb_rd_n, gb_wr_n, gb_cs_n, gb_dout_oe} !== es)
          $display("FAIL trace_strobes n=%0d k=%0d got %b want %b", n, k,
                   {gb_rd_n, gb_wr_n, gb_cs_n, gb_dout_oe}, es);
        else passes++;
        checks++;
        if (gb_addr !== ba[(k < total) ? idx : nb - 1])
          $display("FAIL trace_addr n=%0d k=%0d got %h want %h", n, k, gb_addr,
                   ba[(k < total) ? idx : nb - 1]);
        else passes++;
        checks++;
        if ({rsp_valid, cmd_ready} !== {k == total, 1'b0})
          $display("FAIL trace_valid_ready n=%0d k=%0d got %b want %b", n, k,
                   {rsp_valid, cmd_ready}, {k == total, 1'b0});
        else passes++;
        if (k < total && bw[idx]) begin
          checks++;
          if (gb_dout !== bd[idx])
            $display("FAIL trace_dout n=%0d k=%0d got %h want %h", n, k, gb_dout, bd[idx]);
          else passes++;
        end
        if (k == 1 || k == total) begin
          checks++;
          if (rsp_rdata !== exp_rdata)
            $display("FAIL trace_rdata n=%0d k=%0d got %h want %h", n, k, rsp_rdata, exp_rdata);
          else passes++;
        end
        cmd_valid = (k < total) ? 1'($urandom) : 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom);
        cmd_bank  = 9'($urandom);
        gb_din = (n == 2 && stb) ? 8'hC3 : 8'($urandom);
        if (last && !bw[idx]) exp_rdata = gb_din;
        step();
      end
      checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10)
        $display("FAIL idle_after n=%0d got %b want 10", n, {cmd_ready, rsp_valid});
      else passes++;
      for (int i = 0; i < nb; i++) begin
        if (bw[i] && ba[i][15:12] == 4'h2) begin m_bank[7:0] = bd[i]; m_lo_v = 1; end
        if (bw[i] && ba[i][15:12] == 4'h3) begin m_bank[8] = bd[i][0]; m_hi_v = 1; end
      end
    end
  endtask

  task automatic test_back_to_back();
    gb_din = 8'h77;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0234; cmd_bank = '0;
    step();
    cmd_addr = 16'h1678;
    for (int k = 1; k <= L + 1; k++) begin
      checks++;
      if ({cmd_ready, gb_addr} !== {1'b0, 16'h0234})
        $display("FAIL b2b_busy k=%0d got %b/%h want 0/0234", k, cmd_ready, gb_addr);
      else passes++;
      step();
    end
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL b2b_idle_gap got %b want 1", cmd_ready);
    else passes++;
    step();
    checks++;
    if ({cmd_ready, gb_addr} !== {1'b0, 16'h1678})
      $display("FAIL b2b_second got %b/%h want 0/1678", cmd_ready, gb_addr);
    else passes++;
    cmd_valid = 1'b0;
    repeat (L + 1) step();
    exp_rdata = 8'h77;
    checks++;
    if ({cmd_ready, rsp_rdata} !== {1'b1, exp_rdata})
      $display("FAIL b2b_end got %b/%h want 1/%h", cmd_ready, rsp_rdata, exp_rdata);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int seen;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0150;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (gb_rd_n !== 1'b0) $display("FAIL rstmid_in_strobe got %b want 0", gb_rd_n);
    else passes++;
    rst_n = 1'b0;
    step();
    checks++;
    if ({gb_rd_n, gb_wr_n, gb_cs_n, gb_dout_oe, rsp_valid, cmd_ready} !== 6'b111000)
      $display("FAIL rstmid_ctrl got %b want 111000",
               {gb_rd_n, gb_wr_n, gb_cs_n, gb_dout_oe, rsp_valid, cmd_ready});
    else passes++;
    checks++;
    if ({gb_addr, rsp_rdata} !== 24'h0)
      $display("FAIL rstmid_data got %h want 000000", {gb_addr, rsp_rdata});
    else passes++;
    rst_n = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", cmd_ready);
    else passes++;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) $display("FAIL rstmid_no_rsp got %0d pulses want 0", seen);
    else passes++;
    exp_rdata = '0;
    m_lo_v = 0;
    m_hi_v = 0;
  endtask

  initial begin
    test_reset();
    test_transactions();
    test_back_to_back();
    test_reset_mid();
    test_transactions();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gb_cart_bus_master.md
GB_CART_BUS_MASTER -- requirements
Module: gb_cart_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, cycles address/data are stable before the strobe (legal range 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 4, cycles RD_n/WR_n are held low (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 2, cycles address/data are held after the strobe rises (legal range 1..15).
REQ-004 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1, host request present.
REQ-007 SHALL have port cmd_ready, output, 1, block can accept a request.
REQ-008 SHALL have port cmd_write, input, 1, 1 = cartridge write, 0 = cartridge read.
REQ-009 SHALL have port cmd_addr, input, 16, GB bus address A15..A0.
REQ-010 SHALL have port cmd_wdata, input, 8, write data.
REQ-011 SHALL have port cmd_bank, input, 9, target MBC5 ROM bank for reads at 0x4000-0x7FFF (used only per REQ-032).
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, 8, read data; held until the next read completes.
REQ-014 SHALL have ports gb_addr (output, 16), gb_dout (output, 8), gb_dout_oe (output, 1), gb_din (input, 8): cartridge bus address, write data, data driver enable, read data.
REQ-015 SHALL have ports gb_rd_n, gb_wr_n, gb_cs_n, each output, 1: active-low read strobe, write strobe, external-RAM chip select.

Function
REQ-016 SHALL have states IDLE, SETUP, STROBE, HOLD, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with cmd_valid=1 and cmd_ready=1, latching cmd_write/addr/wdata/bank, and enter SETUP.
REQ-018 SHALL, from acceptance edge T, occupy SETUP for SETUP_CYC cycles, STROBE for STROBE_CYC cycles and HOLD for HOLD_CYC cycles, then DONE for exactly one cycle, then IDLE.
REQ-019 SHALL assert rsp_valid only in DONE, i.e. SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles after T (9 with defaults), for both reads and writes.
REQ-020 SHALL drive gb_addr with the latched address from SETUP through HOLD; in IDLE it SHALL hold its last value.
REQ-021 SHALL drive gb_cs_n=0 from SETUP through HOLD when the latched address is in 0xA000-0xBFFF, else 1.
REQ-022 SHALL drive gb_rd_n=0 in STROBE for reads only and gb_wr_n=0 in STROBE for writes only; both 1 in all other states.
REQ-023 SHALL, for writes, drive gb_dout=wdata with gb_dout_oe=1 from SETUP through HOLD; gb_dout_oe=0 otherwise and always for reads.
REQ-024 SHALL capture gb_din into rsp_rdata on the last STROBE cycle of a read; writes SHALL not change rsp_rdata.
REQ-025 SHALL never assert gb_rd_n and gb_wr_n low simultaneously.
REQ-026 SHALL ignore cmd_valid outside IDLE; no queuing; back-to-back requests incur at least one IDLE cycle.

Reset
REQ-027 SHALL, while rst_n=0 at a rising edge, force state IDLE; gb_rd_n, gb_wr_n and gb_cs_n to 1; gb_dout_oe, rsp_valid and cmd_ready to 0; gb_addr, gb_dout and rsp_rdata to 0.
REQ-028 SHALL, on reset mid-transaction, abandon it with strobes high on the next edge and no rsp_valid.
REQ-029 SHALL raise cmd_ready on the first edge with rst_n=1.

Configuration
REQ-030 SHALL provide macro GB_CART_BUS_MASTER_AUTO_BANK_EN.
REQ-031 SHALL, without the macro, ignore cmd_bank and perform exactly one bus cycle per request.
REQ-032 SHALL, with the macro, before a read with addr[15:14]=01 whose cmd_bank differs from the cached bank (or the cache is invalid), insert a write of bank[7:0] to 0x2000, then a write of {7'b0,bank[8]} to 0x3000, each a full SETUP/STROBE/HOLD cycle with no DONE, no IDLE in between and no rsp_valid; the read follows immediately.
REQ-033 SHALL, with the macro, mark the bank cache invalid on reset and update it from auto-writes and host writes to 0x2000-0x2FFF (bits 7:0) and 0x3000-0x3FFF (bit 8); the cache SHALL become valid only after both halves are written.

Verification
REQ-034 SHALL cover: read 0x0150 with gb_din=0xC3 -> rd_n low cycles T+3..T+6, rsp_valid at T+9, rsp_rdata=0xC3, cs_n=1.
REQ-035 SHALL cover: write 0xA000<-0x5A -> cs_n=0, wr_n low 4 cycles, gb_dout=0x5A with oe=1 T+1..T+8, rsp_valid at T+9.
REQ-036 SHALL cover: cmd_valid held high continuously -> second acceptance no earlier than T+10, ready low T+1..T+9.
REQ-037 SHALL cover: rst_n=0 during STROBE of a read -> next edge rd_n=1, state IDLE, no rsp_valid.
REQ-038 SHALL cover (macro on): read 0x4000 bank 0x105 after reset -> writes 0x2000<-0x05, 0x3000<-0x01, then read; rsp_valid at T+25; repeated read with bank 0x105 -> rsp_valid at T+9.
